// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM driver: the duty-triple bundle,
// the default period length and the active-low LED levels.
package rgb_pkg;

   localparam int PWM_INTERVAL_DEFAULT = 1200;
   localparam int CNT_W                = 16;
   localparam int REQ_W                = 32;

   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;

   typedef struct packed {
      logic [REQ_W-1:0] r;
      logic [REQ_W-1:0] g;
      logic [REQ_W-1:0] b;
   } rgb_duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One colour: saturates the requested duty, holds pending/active values and
// registers the active-low compare output against the shared counter.
module pwm_channel
   import rgb_pkg::*;
#(
   parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [REQ_W-1:0] i_duty,
   input  logic             i_load_pend,
   input  logic             i_load_act_pend,
   input  logic             i_load_act_direct,
   output logic             o_pin
);

   logic [CNT_W-1:0] r_pend;
   logic [CNT_W-1:0] r_act;
   logic [CNT_W-1:0] w_duty_sat;

   function automatic logic [CNT_W-1:0] sat_duty(input logic [REQ_W-1:0] d);
      if (d > REQ_W'(PWM_INTERVAL))
         return CNT_W'(PWM_INTERVAL);
      return d[CNT_W-1:0];
   endfunction

   assign w_duty_sat = sat_duty(i_duty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
         r_act  <= '0;
         o_pin  <= LED_OFF;
      end else begin
         if (i_load_pend)
            r_pend <= w_duty_sat;
         if (i_load_act_pend)
            r_act <= r_pend;
         else if (i_load_act_direct)
            r_act <= w_duty_sat;
         // Compare uses the counter value of this cycle; the pin shows it next cycle.
         o_pin <= (i_cnt < r_act) ? LED_ON : LED_OFF;
      end
   end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver: shared period counter, single-entry pending
// buffer with ready/valid handshake, updates applied only at the period wrap.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
   parameter int DUTY_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty_r,
   input  logic [DUTY_W-1:0] duty_g,
   input  logic [DUTY_W-1:0] duty_b,
   input  logic              duty_valid,
   output logic              duty_ready,
   output logic              period_start,
   output logic              RGB_R,
   output logic              RGB_G,
   output logic              RGB_B
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_INTERVAL - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_pending_full;
   logic             w_wrap;
   logic             w_xfer;
   logic             w_load_pend;
   logic             w_load_act_pend;
   logic             w_load_act_direct;
   rgb_duty_t        w_req;

   assign w_wrap            = (r_cnt == CNT_LAST);
   assign duty_ready        = ~r_pending_full;
   assign w_xfer            = duty_valid & ~r_pending_full;
   assign w_load_pend       = w_xfer & ~w_wrap;
   assign w_load_act_pend   = w_wrap & r_pending_full;
   // A transfer on the wrap cycle can only happen with pending empty, so it bypasses pending.
   assign w_load_act_direct = w_wrap & w_xfer;

   assign w_req = '{r: REQ_W'(duty_r), g: REQ_W'(duty_g), b: REQ_W'(duty_b)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt          <= '0;
         r_pending_full <= 1'b0;
         period_start   <= 1'b0;
      end else begin
         r_cnt          <= w_wrap ? '0 : r_cnt + 1'b1;
         period_start   <= (r_cnt == '0);
         if (w_wrap)
            r_pending_full <= 1'b0;
         else if (w_xfer)
            r_pending_full <= 1'b1;
      end
   end

   pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_r (
      .clk               (clk),
      .rst               (rst),
      .i_cnt             (r_cnt),
      .i_duty            (w_req.r),
      .i_load_pend       (w_load_pend),
      .i_load_act_pend   (w_load_act_pend),
      .i_load_act_direct (w_load_act_direct),
      .o_pin             (RGB_R)
   );

   pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_g (
      .clk               (clk),
      .rst               (rst),
      .i_cnt             (r_cnt),
      .i_duty            (w_req.g),
      .i_load_pend       (w_load_pend),
      .i_load_act_pend   (w_load_act_pend),
      .i_load_act_direct (w_load_act_direct),
      .o_pin             (RGB_G)
   );

   pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_b (
      .clk               (clk),
      .rst               (rst),
      .i_cnt             (r_cnt),
      .i_duty            (w_req.b),
      .i_load_pend       (w_load_pend),
      .i_load_act_pend   (w_load_act_pend),
      .i_load_act_direct (w_load_act_direct),
      .o_pin             (RGB_B)
   );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver with a 10-cycle period: directed scenarios followed by
// random duty offers, compared against a period-level queue model.
module tb_rgb_pwm_driver;

   localparam int P = 10;
   localparam int W = 4;

   typedef struct {
      int r;
      int g;
      int b;
   } trip_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] duty_r = '0;
   logic [W-1:0] duty_g = '0;
   logic [W-1:0] duty_b = '0;
   logic         duty_valid = 1'b0;
   logic         duty_ready;
   logic         period_start;
   logic         RGB_R, RGB_G, RGB_B;

   int    tests = 0;
   int    fails = 0;
   int    m_cnt = 0;
   int    last_acc_cnt = -1;
   trip_t act = '{0, 0, 0};
   trip_t offer = '{0, 0, 0};
   trip_t q[$];
   bit    o_v = 1'b0;
   logic  prev_r = 1'b1;

   rgb_pwm_driver #(.PWM_INTERVAL(P), .DUTY_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .duty_r       (duty_r),
      .duty_g       (duty_g),
      .duty_b       (duty_b),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .period_start (period_start),
      .RGB_R        (RGB_R),
      .RGB_G        (RGB_G),
      .RGB_B        (RGB_B)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int d);
      return (d > P) ? P : d;
   endfunction

   task automatic set_offer(input int r, input int g, input int b);
      offer = '{r, g, b};
      o_v   = 1'b1;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step();
      bit    xfer;
      int    c;
      trip_t a;
      int    er, eg, eb, eps;
      duty_valid = o_v;
      duty_r     = offer.r[W-1:0];
      duty_g     = offer.g[W-1:0];
      duty_b     = offer.b[W-1:0];
      #1;
      check("ready", {31'b0, duty_ready}, (q.size() == 0) ? 1 : 0);
      xfer = !rst && o_v && (q.size() == 0);
      c = m_cnt;
      a = act;
      @(posedge clk);
      if (rst) begin
         q.delete();
         act = '{0, 0, 0};
         m_cnt = 0;
         er = 1; eg = 1; eb = 1; eps = 0;
      end else begin
         er  = (c < a.r) ? 0 : 1;
         eg  = (c < a.g) ? 0 : 1;
         eb  = (c < a.b) ? 0 : 1;
         eps = (c == 0) ? 1 : 0;
         if (xfer) begin
            q.push_back('{sat(offer.r), sat(offer.g), sat(offer.b)});
            o_v = 1'b0;
            last_acc_cnt = c;
         end
         if (c == P - 1 && q.size() > 0)
            act = q.pop_front();
         m_cnt = (c + 1) % P;
      end
      #1;
      check("pin_r", {31'b0, RGB_R}, er);
      check("pin_g", {31'b0, RGB_G}, eg);
      check("pin_b", {31'b0, RGB_B}, eb);
      check("period_start", {31'b0, period_start}, eps);
      if (prev_r === 1'b1 && RGB_R === 1'b0)
         check("fall_align", {31'b0, period_start}, 1);
      prev_r = RGB_R;
      @(negedge clk);
   endtask

   task automatic wait_cnt(input int n);
      for (int i = 0; i < 2 * P && m_cnt != n; i++)
         step();
      check("wait_cnt", m_cnt, n);
   endtask

   task automatic count_period(input string tag, input int er, input int eg, input int eb);
      int cr, cg, cb;
      cr = 0; cg = 0; cb = 0;
      wait_cnt(0);
      for (int i = 0; i < P; i++) begin
         step();
         if (RGB_R === 1'b0) cr++;
         if (RGB_G === 1'b0) cg++;
         if (RGB_B === 1'b0) cb++;
      end
      check({tag, "_r_low"}, cr, er);
      check({tag, "_g_low"}, cg, eg);
      check({tag, "_b_low"}, cb, eb);
   endtask

   initial begin
      // Power-on reset state
      @(negedge clk);
      check("rst_pin_r", {31'b0, RGB_R}, 1);
      check("rst_pin_g", {31'b0, RGB_G}, 1);
      check("rst_pin_b", {31'b0, RGB_B}, 1);
      check("rst_ps", {31'b0, period_start}, 0);
      check("rst_ready", {31'b0, duty_ready}, 1);
      rst = 1'b0;
      prev_r = RGB_R;

      // Basic update accepted mid-period, applied from the next period
      wait_cnt(4);
      set_offer(3, 0, 10);
      step();
      check("basic_acc_cnt", last_acc_cnt, 4);
      check("basic_ready_low", {31'b0, duty_ready}, 0);
      count_period("basic", 3, 0, 10);
      check("basic_ready_high", {31'b0, duty_ready}, 1);

      // Back-pressure: second triple stalls until the wrap
      wait_cnt(2);
      set_offer(5, 0, 0);
      step();
      set_offer(7, 0, 0);
      count_period("bp5", 5, 0, 0);
      check("bp_acc_cnt", last_acc_cnt, 0);
      count_period("bp7", 7, 0, 0);

      // Transfer on the wrap cycle goes straight to active
      wait_cnt(9);
      set_offer(6, 0, 0);
      step();
      check("wrap_acc_cnt", last_acc_cnt, 9);
      check("wrap_ready", {31'b0, duty_ready}, 1);
      count_period("wrap", 6, 0, 0);

      // Saturation of over-range duty values
      set_offer(15, 15, 15);
      step();
      count_period("sat", 10, 10, 10);

      // Mid-period reset with outputs toggling and a pending triple
      set_offer(4, 2, 7);
      step();
      count_period("pre_rst", 4, 2, 7);
      wait_cnt(3);
      set_offer(8, 8, 8);
      step();
      wait_cnt(5);
      rst = 1'b1;
      o_v = 1'b0;
      q.delete();
      act = '{0, 0, 0};
      m_cnt = 0;
      #1;
      check("mid_rst_pin_r", {31'b0, RGB_R}, 1);
      check("mid_rst_pin_g", {31'b0, RGB_G}, 1);
      check("mid_rst_pin_b", {31'b0, RGB_B}, 1);
      check("mid_rst_ps", {31'b0, period_start}, 0);
      check("mid_rst_ready", {31'b0, duty_ready}, 1);
      prev_r = RGB_R;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      count_period("post_rst_a", 0, 0, 0);
      count_period("post_rst_b", 0, 0, 0);

      // Random offers against the queue model
      for (int i = 0; i < 200; i++) begin
         if (!o_v && $urandom_range(0, 2) == 0)
            set_offer(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
